// File: rtl/half_subtractor.sv
// Lane-parallel half subtractor with a registered, valid-qualified result and aggregate borrow flags.
// Defining HALF_SUB_COMB_OUT_EN switches every output to a zero-latency combinational path.
module half_subtractor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff_out,
  output logic [WIDTH-1:0] borr_out,
  output logic             borr_any,
  output logic [CNT_W-1:0] borr_cnt
);

  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] borr_d;
  logic             any_d;
  logic [CNT_W-1:0] cnt_d;

  // Lanes are independent: no borrow ripples between them.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    assign diff_d[gi] = a_in[gi] ^ b_in[gi];
    assign borr_d[gi] = ~a_in[gi] & b_in[gi];
  end

  assign any_d = |borr_d;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d = cnt_d + CNT_W'(borr_d[i]);
    end
  end

`ifdef HALF_SUB_COMB_OUT_EN
  logic unused_ok;
  assign unused_ok = clk ^ rst;

  assign out_valid = in_valid;
  assign diff_out  = diff_d;
  assign borr_out  = borr_d;
  assign borr_any  = any_d;
  assign borr_cnt  = cnt_d;
`else
  logic             valid_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] borr_q;
  logic             any_q;
  logic [CNT_W-1:0] cnt_q;

  // Data registers only load on valid, so undriven inputs during idle cycles never reach them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      diff_q  <= '0;
      borr_q  <= '0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        diff_q <= diff_d;
        borr_q <= borr_d;
        any_q  <= any_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign diff_out  = diff_q;
  assign borr_out  = borr_q;
  assign borr_any  = any_q;
  assign borr_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// Bench for half_subtractor: a 4-lane and a 1-lane instance share stimulus (the 1-lane one sees lane 0).
// Expected results are queued when stimulus is driven and popped after the clock edge that produces them.
module tb_half_subtractor;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a4;
  logic [3:0] b4;

  logic       v4_o, any4_o;
  logic [3:0] d4_o, b4_o;
  logic [2:0] c4_o;
  logic       v1_o, any1_o;
  logic [0:0] d1_o, b1_o;
  logic [0:0] c1_o;

  half_subtractor #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_in(a4), .b_in(b4),
    .out_valid(v4_o), .diff_out(d4_o), .borr_out(b4_o), .borr_any(any4_o), .borr_cnt(c4_o)
  );

  half_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_in(a4[0]), .b_in(b4[0]),
    .out_valid(v1_o), .diff_out(d1_o), .borr_out(b1_o), .borr_any(any1_o), .borr_cnt(c1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [3:0] b;
    logic       any;
    logic [2:0] cnt;
  } exp_t;

  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   txn       = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s txn %0d: got %0h required %0h", nm, txn, act, exp);
    else pass_cnt++;
  endtask

  // Drive one cycle of stimulus, push its expected result, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b, input exp_t e);
    exp_t x;
    rst = r; in_valid = v; a4 = a; b4 = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    $display("txn %0d rst=%b vld=%b a=%b b=%b -> v=%b d=%b brw=%b any=%b cnt=%0d",
             txn, r, v, a, b, v4_o, d4_o, b4_o, any4_o, c4_o);
    chk("w4_valid", 32'(v4_o), 32'(x.v));
    chk("w4_diff", 32'(d4_o), 32'(x.d));
    chk("w4_borr", 32'(b4_o), 32'(x.b));
    chk("w4_any", 32'(any4_o), 32'(x.any));
    chk("w4_cnt", 32'(c4_o), 32'(x.cnt));
    chk("w1_valid", 32'(v1_o), 32'(x.v));
    chk("w1_diff", 32'(d1_o), 32'(x.d[0]));
    chk("w1_borr", 32'(b1_o), 32'(x.b[0]));
    chk("w1_any", 32'(any1_o), 32'(x.b[0]));
    chk("w1_cnt", 32'(c1_o), 32'(x.b[0]));
    txn++;
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                              input logic ev, input logic [3:0] ed, input logic [3:0] eb,
                              input logic ea, input logic [2:0] ec);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.b = b;
    t.e.v = ev; t.e.d = ed; t.e.b = eb; t.e.any = ea; t.e.cnt = ec;
    return t;
  endfunction

  vec_t vecs[21];

  initial begin
    exp_t       e;
    logic [3:0] ra, rb;
    logic       rv;
    exp_t       m;

    // Reset held 2 cycles with valid data present, then released.
    vecs[0]  = mk(1, 1, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
    vecs[1]  = mk(1, 1, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
    vecs[2]  = mk(0, 1, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 0, 0);
    // Lane-0 truth table back to back.
    vecs[3]  = mk(0, 1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0);
    vecs[4]  = mk(0, 1, 4'b0000, 4'b0001, 1, 4'b0001, 4'b0001, 1, 1);
    vecs[5]  = mk(0, 1, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 0, 0);
    vecs[6]  = mk(0, 1, 4'b0001, 4'b0001, 1, 4'b0000, 4'b0000, 0, 0);
    // Multi-lane and all-borrow (count reaches WIDTH without wrapping).
    vecs[7]  = mk(0, 1, 4'b0011, 4'b0101, 1, 4'b0110, 4'b0100, 1, 1);
    vecs[8]  = mk(0, 1, 4'b0000, 4'b1111, 1, 4'b1111, 4'b1111, 1, 4);
    // Hold while in_valid is low.
    vecs[9]  = mk(0, 1, 4'b0000, 4'b0001, 1, 4'b0001, 4'b0001, 1, 1);
    vecs[10] = mk(0, 0, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0001, 1, 1);
    vecs[11] = mk(0, 0, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0001, 1, 1);
    vecs[12] = mk(0, 0, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0001, 1, 1);
    // Mixed lanes.
    vecs[13] = mk(0, 1, 4'b1010, 4'b0110, 1, 4'b1100, 4'b0100, 1, 1);
    vecs[14] = mk(0, 1, 4'b0101, 4'b1110, 1, 4'b1011, 4'b1010, 1, 2);
    vecs[15] = mk(0, 1, 4'b0000, 4'b0111, 1, 4'b0111, 4'b0111, 1, 3);
    // Mid-stream reset, resume, X while idle, reset overriding idle.
    vecs[16] = mk(1, 1, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
    vecs[17] = mk(0, 1, 4'b1100, 4'b1010, 1, 4'b0110, 4'b0010, 1, 1);
    vecs[18] = mk(0, 0, 4'bxxxx, 4'bxxxx, 0, 4'b0110, 4'b0010, 1, 1);
    vecs[19] = mk(0, 1, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0);
    vecs[20] = mk(1, 0, 4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0);

    rst = 1'b1; in_valid = 1'b0; a4 = '0; b4 = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].e);
    end

    // Random back-to-back stream against a small reference model with hold behaviour.
    m.v = 0; m.d = '0; m.b = '0; m.any = 0; m.cnt = '0;
    for (int i = 0; i < 40; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      m.v = rv;
      if (rv) begin
        m.d = ra ^ rb;
        m.b = ~ra & rb;
        m.any = |m.b;
        m.cnt = 3'(m.b[0]) + 3'(m.b[1]) + 3'(m.b[2]) + 3'(m.b[3]);
      end
      e = m;
      step(1'b0, rv, ra, rb, e);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/half_subtractor.md
Name: half_subtractor

Overview:
- Registered, lane-parallel half subtractor. Each lane computes a single-bit difference and borrow: a_in minus b_in, with no borrow-in.
- Used as a leaf arithmetic cell in combinational/datapath exercises. The default WIDTH=1 gives the classic 1-bit half subtractor with a one-cycle registered output.
- Adds a valid qualifier plus aggregate borrow flags so it can be chained into pipelined datapaths.

Parameters:
- WIDTH, 1, number of independent half-subtractor lanes (>=1).
- CNT_W, $clog2(WIDTH+1), width of the borrow population count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  qualifies a_in/b_in this cycle
- a_in  input  WIDTH  minuend bits, one per lane
- b_in  input  WIDTH  subtrahend bits, one per lane
- out_valid  output  1  diff_out/borr_out/borr_any/borr_cnt hold a valid result
- diff_out  output  WIDTH  per-lane difference: a_in XOR b_in
- borr_out  output  WIDTH  per-lane borrow: (NOT a_in) AND b_in
- borr_any  output  1  OR-reduction of borr_out
- borr_cnt  output  CNT_W  number of lanes with borrow set

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs clear: out_valid=0, diff_out=0, borr_out=0, borr_any=0, borr_cnt=0.
  - rst has priority over in_valid in the same cycle.
- Per-lane truth table (a,b -> diff,borr): 0,0 -> 0,0; 0,1 -> 1,1; 1,0 -> 1,0; 1,1 -> 0,0.
- Latency: exactly 1 cycle. Inputs sampled with in_valid=1 at edge N appear on the outputs after edge N.
- out_valid follows in_valid with the same 1-cycle delay. It is deasserted after any edge where in_valid=0.
- When in_valid=0, the data outputs hold their last valid values (no update). Only out_valid drops.
- Lanes are fully independent. There is no carry or borrow propagation between lanes.
- borr_any and borr_cnt are computed from the same sampled inputs as borr_out and are registered in the same cycle. They are never skewed.
- borr_cnt range is 0..WIDTH. CNT_W is sized so that WIDTH borrows cannot wrap.
- Back-to-back valid inputs produce back-to-back valid outputs. There is no stall and no backpressure.
- Reset mid-stream: the result in flight is discarded. The first valid output after reset corresponds to the first in_valid=1 sampled while rst=0.
- X on a_in/b_in while in_valid=0 must not propagate into the held outputs.

Optional Feature:
- Macro HALF_SUB_COMB_OUT_EN.
- When defined:
  - diff_out, borr_out, borr_any and borr_cnt are driven combinationally from a_in/b_in. This is zero latency, with the data outputs not gated by in_valid.
  - out_valid equals in_valid combinationally.
  - rst has no effect on the data paths.
- When undefined (default): the registered 1-cycle behaviour described above applies.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a_in=1, b_in=0 -> all outputs 0 during and 1 cycle after reset release edge; then diff_out=1, borr_out=0, out_valid=1.
- Truth table, WIDTH=1: apply (0,0), (0,1), (1,0), (1,1) on consecutive cycles with in_valid=1.
  - diff_out must read 0, 1, 1, 0 one cycle later.
  - borr_out must read 0, 1, 0, 0.
  - borr_any must equal borr_out.
- Hold: valid (0,1), then in_valid=0 with a_in=1, b_in=1 for 3 cycles -> out_valid=0, diff_out stays 1, borr_out stays 1.
- Multi-lane, WIDTH=4: a_in=4'b0011, b_in=4'b0101 -> diff_out=4'b0110, borr_out=4'b0100, borr_any=1, borr_cnt=1.
- All-borrow, WIDTH=4: a_in=4'b0000, b_in=4'b1111 -> diff_out=4'b1111, borr_out=4'b1111, borr_cnt=4, no wrap.
- Mid-stream reset: stream valid inputs, assert rst for 1 cycle -> next cycle out_valid=0 and all outputs 0; stream resumes with correct 1-cycle latency.
